// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_pkg
// Description : Shared state encoding and sample-range constants for the
//               ADC capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

    localparam int c_w_default = 24;

    // Signed extremes used to seed the peak trackers at the default width.
    localparam logic [c_w_default-1:0] c_smax_default = {1'b0, {(c_w_default-1){1'b1}}};
    localparam logic [c_w_default-1:0] c_smin_default = {1'b1, {(c_w_default-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_ram
// Description : Simple dual-port capture buffer, DEPTH x W, synchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_ram #(
    parameter int DEPTH = 1024,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture
// Description : Triggered single-channel ADC capture into a DEPTH-sample
//               buffer with signed peak tracking and 1-cycle-latency readout.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int W     = c_w_default
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ready,
    input  logic [W-1:0] l_in,
    input  logic [W-1:0] r_in,
    input  logic         ch_sel,
    input  logic         trig_mode,
    input  logic [W-1:0] trig_level,
    input  logic         arm,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic         rd_last,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] peak_max,
    output logic [W-1:0] peak_min
);

    localparam int             c_aw   = $clog2(DEPTH);
    localparam logic [c_aw-1:0] c_last = c_aw'(DEPTH - 1);
    localparam logic [c_aw-1:0] c_one  = c_aw'(1);
    localparam logic [W-1:0]   c_smax = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]   c_smin = {1'b1, {(W-1){1'b0}}};

    state_t          state_q, state_d;
    logic            ready_q;
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic            have_prev_q, have_prev_d;
    logic [W-1:0]    prev_q, prev_d;
    logic [W-1:0]    peak_max_q, peak_max_d;
    logic [W-1:0]    peak_min_q, peak_min_d;
    logic            busy_q, done_q, rd_valid_q, rd_last_q;

    logic            w_event;
    logic [W-1:0]    w_cur;
    logic            w_trig;
    logic [W-1:0]    w_new_max, w_new_min;
    logic            w_we, w_re;
    logic [c_aw-1:0] w_waddr;
    logic [W-1:0]    w_ram_rdata;

    assign w_event   = ready & ~ready_q;
    assign w_cur     = ch_sel ? r_in : l_in;
    assign w_trig    = have_prev_q
                     && ($signed(prev_q) < $signed(trig_level))
                     && ($signed(trig_level) <= $signed(w_cur));
    assign w_new_max = ($signed(w_cur) > $signed(peak_max_q)) ? w_cur : peak_max_q;
    assign w_new_min = ($signed(w_cur) < $signed(peak_min_q)) ? w_cur : peak_min_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        peak_max_d  = peak_max_q;
        peak_min_d  = peak_min_q;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_waddr     = wr_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d     = ST_ARMED;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    have_prev_d = 1'b0;
                    peak_max_d  = c_smin;
                    peak_min_d  = c_smax;
                end
            end
            ST_ARMED: begin
                if (w_event) begin
                    prev_d      = w_cur;
                    have_prev_d = 1'b1;
                    if (!trig_mode || w_trig) begin
                        w_we       = 1'b1;
                        w_waddr    = '0;
                        wr_ptr_d   = c_one;
                        peak_max_d = w_new_max;
                        peak_min_d = w_new_min;
                        state_d    = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (w_event) begin
                    w_we       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + c_one;
                    peak_max_d = w_new_max;
                    peak_min_d = w_new_min;
                    if (wr_ptr_q == c_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A simultaneous arm takes priority and suppresses the read.
                if (arm) begin
                    state_d     = ST_ARMED;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    have_prev_d = 1'b0;
                    peak_max_d  = c_smin;
                    peak_min_d  = c_smax;
                end else if (rd_en) begin
                    w_re     = 1'b1;
                    rd_ptr_d = rd_ptr_q + c_one;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            peak_max_q  <= '0;
            peak_min_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            peak_max_q  <= peak_max_d;
            peak_min_q  <= peak_min_d;
            busy_q      <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
            done_q      <= (state_d == ST_DONE);
            rd_valid_q  <= w_re;
            rd_last_q   <= w_re && (rd_ptr_q == c_last);
        end
    end

    adc_capture_ram #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_capture_ram (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (w_cur),
        .re_i    (w_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_ram_rdata)
    );

    assign rd_data  = rd_valid_q ? w_ram_rdata : '0;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign peak_max = peak_max_q;
    assign peak_min = peak_min_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture
// Description : Self-checking bench for adc_capture with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture;

    localparam int DEPTH = 8;
    localparam int W     = 24;

    localparam int P_IDLE = 0, P_ARMED = 1, P_CAPT = 2, P_DONE = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] l_in = '0;
    logic [W-1:0] r_in = '0;
    logic         ch_sel = 1'b0;
    logic         trig_mode = 1'b0;
    logic [W-1:0] trig_level = '0;
    logic         arm = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] rd_data;
    logic         rd_valid, rd_last, busy, done;
    logic [W-1:0] peak_max, peak_min;

    int n_checks = 0;
    int n_fail   = 0;

    adc_capture #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ready      (ready),
        .l_in       (l_in),
        .r_in       (r_in),
        .ch_sel     (ch_sel),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .arm        (arm),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .busy       (busy),
        .done       (done),
        .peak_max   (peak_max),
        .peak_min   (peak_min)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int si(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [W-1:0] sv(input int x);
        return x[W-1:0];
    endfunction

    // ---------------- behavioural model ----------------
    int           m_phase = P_IDLE;
    bit           m_live = 0;
    bit           m_rdy_prev = 0;
    bit           m_have_prev = 0;
    int           m_prev = 0;
    bit           m_peak_zero = 1;
    int           m_rptr = 0;
    logic [W-1:0] m_mem [DEPTH];
    logic [W-1:0] cap_q [$];
    bit           m_rv = 0, m_rl = 0;
    logic [W-1:0] m_rd = '0;

    function automatic logic [W-1:0] exp_max();
        int m;
        if (m_peak_zero) return '0;
        m = -(1 << (W-1));
        foreach (cap_q[i]) if (si(cap_q[i]) > m) m = si(cap_q[i]);
        return m[W-1:0];
    endfunction

    function automatic logic [W-1:0] exp_min();
        int m;
        if (m_peak_zero) return '0;
        m = (1 << (W-1)) - 1;
        foreach (cap_q[i]) if (si(cap_q[i]) < m) m = si(cap_q[i]);
        return m[W-1:0];
    endfunction

    task automatic m_start();
        m_phase = P_ARMED;
        cap_q.delete();
        m_rptr = 0;
        m_have_prev = 0;
        m_peak_zero = 0;
    endtask

    task automatic m_store(input logic [W-1:0] v);
        cap_q.push_back(v);
        m_mem[cap_q.size()-1] = v;
        m_phase = (cap_q.size() == DEPTH) ? P_DONE : P_CAPT;
    endtask

    always @(posedge clk) begin
        bit           ev;
        logic [W-1:0] cur;
        ev  = ready && !m_rdy_prev;
        cur = ch_sel ? r_in : l_in;
        m_rv = 0;
        m_rl = 0;
        if (!reset_n) begin
            m_live = 1;
            m_phase = P_IDLE;
            m_rdy_prev = 0;
            m_have_prev = 0;
            m_peak_zero = 1;
            m_rptr = 0;
            cap_q.delete();
        end else begin
            m_rdy_prev = ready;
            case (m_phase)
                P_IDLE: if (arm) m_start();
                P_ARMED: if (ev) begin
                    if (!trig_mode || (m_have_prev && m_prev < si(trig_level) && si(trig_level) <= si(cur)))
                        m_store(cur);
                    m_prev = si(cur);
                    m_have_prev = 1;
                end
                P_CAPT: if (ev) m_store(cur);
                default: begin
                    if (arm) m_start();
                    else if (rd_en) begin
                        m_rv = 1;
                        m_rd = m_mem[m_rptr];
                        m_rl = (m_rptr == DEPTH-1);
                        m_rptr = (m_rptr + 1) % DEPTH;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", busy, (m_phase == P_ARMED || m_phase == P_CAPT));
            chk("done", done, (m_phase == P_DONE));
            chk("rd_valid", rd_valid, m_rv);
            chk("rd_last", rd_last, m_rl);
            if (m_rv) chk("rd_data", rd_data, m_rd);
            chk("peak_max", peak_max, exp_max());
            chk("peak_min", peak_min, exp_min());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic send(input int lv, input int rv, input int hold, input int gap);
        l_in  = sv(lv);
        r_in  = sv(rv);
        ready = 1'b1;
        repeat (hold) tick();
        ready = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic read_expect(input int base, input int step);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1;
            tick();
            chk("lit_rd_valid", rd_valid, 1'b1);
            chk("lit_rd_data", rd_data, sv(base + i*step));
            chk("lit_rd_last", rd_last, (i == DEPTH-1));
        end
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_peak_max", peak_max, '0);
        chk("rst_peak_min", peak_min, '0);
        reset_n = 1'b1;
        tick();

        // Immediate mode, left channel, values 1..8; stray read while capturing.
        pulse_arm();
        chk("arm_busy", busy, 1'b1);
        chk("arm_peak_max", peak_max, 24'h800000);
        chk("arm_peak_min", peak_min, 24'h7fffff);
        for (int i = 1; i <= DEPTH; i++) begin
            send(i, -i, 1, 1);
            if (i == 3) begin
                rd_en = 1'b1;
                tick();
                rd_en = 1'b0;
                tick();
                chk("capt_no_rd_valid", rd_valid, 1'b0);
            end
        end
        chk("m0_done", done, 1'b1);
        chk("m0_peak_max", peak_max, sv(8));
        chk("m0_peak_min", peak_min, sv(1));
        read_expect(1, 1);

        // Restart from DONE; ready held high counts once.
        pulse_arm();
        send(42, 0, 5, 2);
        chk("hold_busy", busy, 1'b1);
        chk("hold_peak_max", peak_max, sv(42));
        chk("hold_peak_min", peak_min, sv(42));
        for (int i = 1; i < DEPTH; i++) send(42 + i, 0, 2, 1);
        chk("hold_done", done, 1'b1);
        read_expect(42, 1);

        // Rising-level trigger at 0: 4,6 then -3,-1,2 -> triggers on 2.
        trig_mode  = 1'b1;
        trig_level = '0;
        pulse_arm();
        send(4, 0, 1, 1);
        send(6, 0, 1, 1);
        chk("trig_not_yet", peak_max, 24'h800000);
        send(-3, 0, 1, 1);
        send(-1, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) send(2 + 3*i, 0, 1, 1);
        chk("trig_done", done, 1'b1);
        read_expect(2, 3);

        // Arm and read together in DONE: arm wins.
        arm = 1'b1;
        rd_en = 1'b1;
        tick();
        arm = 1'b0;
        rd_en = 1'b0;
        chk("armrd_no_valid", rd_valid, 1'b0);
        chk("armrd_busy", busy, 1'b1);
        trig_mode = 1'b0;

        // Reset mid-capture after 3 samples, then a fresh capture.
        for (int i = 0; i < 3; i++) send(100 + i, 0, 1, 1);
        reset_n = 1'b0;
        tick();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        reset_n = 1'b1;
        tick();
        arm = 1'b1;               // event coinciding with arm is ignored
        l_in = sv(999);
        ready = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        ready = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) send(-10 - i, 0, 1, 1);
        chk("fresh_done", done, 1'b1);
        read_expect(-10, -1);

        // Right channel.
        ch_sel = 1'b1;
        pulse_arm();
        for (int i = 0; i < DEPTH; i++) send(100, -100, 1, 1);
        chk("right_peak_max", peak_max, sv(-100));
        chk("right_peak_min", peak_min, sv(-100));
        read_expect(-100, 0);

        // Randomized captures checked by the model.
        for (int run = 0; run < 8; run++) begin
            trig_mode  = 1'($urandom_range(1));
            trig_level = sv(int'($urandom_range(40)) - 20);
            ch_sel     = 1'($urandom_range(1));
            if ($urandom_range(1) == 1) begin
                arm = 1'b1;
                tick();
                arm = 1'b0;
            end else begin
                pulse_arm();
            end
            for (int e = 0; e < 60 && m_phase != P_DONE; e++) begin
                if ($urandom_range(7) == 0) ch_sel = ~ch_sel;
                if ($urandom_range(7) == 0) trig_level = sv(int'($urandom_range(40)) - 20);
                rd_en = ($urandom_range(5) == 0);
                arm   = ($urandom_range(9) == 0);
                send(int'($urandom_range(80)) - 40, int'($urandom_range(80)) - 40,
                     int'($urandom_range(2)) + 1, int'($urandom_range(1)) + 1);
                rd_en = 1'b0;
                arm   = 1'b0;
            end
            for (int c = 0; c < 14; c++) begin
                rd_en = ($urandom_range(3) != 0);
                tick();
            end
            rd_en = 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter DEPTH, default 1024, capture buffer length in samples; SHALL be a power of two, at least 4.
REQ-002 Parameter W, default 24, sample width in bits; samples are two's complement.
REQ-003 clk  in  1  system clock. Reset is reset_n, synchronous, active-low; clock is clk.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 ready  in  1  codec sample strobe; may stay high for several cycles.
REQ-006 l_in  in  W  left ADC sample from the codec wrapper.
REQ-007 r_in  in  W  right ADC sample from the codec wrapper.
REQ-008 ch_sel  in  1  channel to capture: 0 = left, 1 = right.
REQ-009 trig_mode  in  1  trigger mode: 0 = immediate, 1 = rising level crossing.
REQ-010 trig_level  in  W  signed trigger threshold.
REQ-011 arm  in  1  single-cycle pulse that starts a capture.
REQ-012 rd_en  in  1  readout request pulse.
REQ-013 rd_data  out  W  sample read from the buffer.
REQ-014 rd_valid  out  1  rd_data is valid; asserted for one cycle.
REQ-015 rd_last  out  1  asserted together with rd_valid for buffer index DEPTH-1.
REQ-016 busy  out  1  high in ARMED and CAPTURE.
REQ-017 done  out  1  high in DONE.
REQ-018 peak_max, peak_min  out  W  signed maximum and minimum of the captured samples.

Function
REQ-019 Sample event: SHALL be the first cycle in which ready is 1 after a cycle in which it was 0 (rising edge, registered). A ready held high SHALL count as exactly one event.
REQ-020 At each sample event the selected sample (l_in or r_in, chosen by ch_sel as sampled that cycle) SHALL be taken.
REQ-021 States: IDLE, ARMED, CAPTURE, DONE.
REQ-022 IDLE: on arm go to ARMED; clear the write pointer, the read pointer, have_prev, and reset the peak trackers.
REQ-023 ARMED with trig_mode=0: the first sample event SHALL be written at address 0, and the state goes to CAPTURE.
REQ-024 ARMED with trig_mode=1: the trigger fires when have_prev is set and prev < trig_level <= cur (signed). The triggering sample SHALL be written at address 0. Every event SHALL update prev and set have_prev.
REQ-025 The first event after arm SHALL NOT trigger in mode 1.
REQ-026 CAPTURE: each event SHALL write one sample at wr_ptr, then increment wr_ptr. After the write to address DEPTH-1 the state goes to DONE, giving exactly DEPTH samples.
REQ-027 Peak update: peak_max and peak_min SHALL update on every buffered sample, including the one at address 0. Compares are signed. Before the first sample, peak_max SHALL hold the most negative value and peak_min the most positive value.
REQ-028 arm in ARMED or CAPTURE SHALL be ignored. arm in DONE SHALL restart as from IDLE.
REQ-029 DONE: rd_en SHALL return buf[rd_ptr] on rd_data with rd_valid exactly one cycle later (1-cycle read latency), then increment rd_ptr. rd_ptr wraps from DEPTH-1 to 0.
REQ-030 rd_en outside DONE SHALL be ignored: no rd_valid, rd_ptr unchanged.
REQ-031 rd_en asserted on consecutive cycles SHALL give back-to-back rd_valid.
REQ-032 If arm and rd_en occur in the same DONE cycle, arm wins: no rd_valid.
REQ-033 A sample event coinciding with arm in IDLE SHALL be ignored; sampling starts on the next event.
REQ-034 ch_sel, trig_mode and trig_level changes SHALL take effect at the next sample event, with no other side effects.

Reset
REQ-035 When reset_n=0 at a clk edge: state goes to IDLE, and all pointers, have_prev and the ready-edge register are cleared.
REQ-036 Under reset: rd_valid=0, rd_last=0, busy=0, done=0, rd_data=0, peak_max=0, peak_min=0.
REQ-037 Buffer contents are not cleared by reset.
REQ-038 Reset mid-capture SHALL abort the capture; no further writes occur.

Structure
REQ-039 Shared package: state encoding, the default W=24, and signed min/max constants derived from W.
REQ-040 One sub-module, capture_ram: simple dual-port, synchronous read, inferred as BRAM, DEPTH x W.
REQ-041 All logic is on clk only.

Verification
REQ-042 With DEPTH=8 and mode 0: arm, then 8 left events with values 1..8 -> done=1. Reading 8 times returns 1..8, with rd_last on 8. peak_max=8, peak_min=1.
REQ-043 Mode 1 with trig_level=0: send -3,-1,2,5,... -> buffer[0]=2. The event sequence 4,6 right after arm does not trigger.
REQ-044 Hold ready high for 5 cycles -> exactly one sample is written.
REQ-045 Assert reset_n=0 after 3 of 8 samples -> IDLE, busy=0. A fresh arm then captures 8 new samples correctly.
REQ-046 Issue rd_en in CAPTURE -> no rd_valid. Issue arm and rd_en together in DONE -> restart, with no rd_valid.
REQ-047 Set ch_sel=1 with l_in=100 and r_in=-100 -> all captured samples are -100, peak_max=peak_min=-100.
